// File: rtl/mac_ctrl_pkg.sv
// Shared constants and types for the MAC issue sequencer and the multiplier top.
// The two latencies live here so the multiplier top and the tag pipe depth cannot drift apart.
package mac_ctrl_pkg;

  localparam int unsigned AW      = 4;
  localparam int unsigned PW      = 8;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned MUL_LAT = 12;

  // One tag stage for every cycle between issuing a read and its product arriving.
  localparam int unsigned TAG_DEPTH = RD_LAT + MUL_LAT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

endpackage

// File: rtl/mac_issue_sequencer_if.sv
// Job, operand-BRAM/multiplier and result signals of the MAC issue sequencer.
// The sequencer is the master: it drives the BRAM reads and the result port.
interface mac_issue_sequencer_if
  import mac_ctrl_pkg::*;
();

  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      count;
  logic             mem_en;
  logic [AW-1:0]    mem_addr;
  logic [PW-1:0]    prod_in;
  logic [ACC_W-1:0] result;
  logic             res_valid;
  logic             res_ready;
  logic             busy;

  modport master (
    input  start, base_addr, count, prod_in, res_ready,
    output mem_en, mem_addr, result, res_valid, busy
  );

  modport slave (
    output start, base_addr, count, prod_in, res_ready,
    input  mem_en, mem_addr, result, res_valid, busy
  );

endinterface

// File: rtl/mac_valid_pipe.sv
// DEPTH-stage valid shift register: marks which cycles carry a real product.
// any_busy_o reports entries still in flight behind the current output stage.
module mac_valid_pipe #(
  parameter int unsigned DEPTH = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic out_o,
  output logic any_busy_o
);

  logic [DEPTH-1:0] pipe_q;

  // NOTE: sequential state uses nonblocking (<=) so every stage shifts from its pre-edge value.
  // NOTE: this pipe is reset on purpose; an abort must discard every in-flight tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[DEPTH-2:0], in_i};
    end
  end

  assign out_o      = pipe_q[DEPTH-1];
  assign any_busy_o = |pipe_q[DEPTH-2:0];

endmodule

// File: rtl/mac_issue_sequencer.sv
// Walks the operand BRAMs for one dot-product job, accumulates the multiplier output
// aligned by a valid tag pipe, and returns the sum over a valid/ready port.
module mac_issue_sequencer
  import mac_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  mac_issue_sequencer_if.master bus
);

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  mac_state_e       state_q;
  logic [AW-1:0]    addr_q;
  logic [AW:0]      remain_q;
  logic             mem_en_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             res_valid_q;
  logic             busy_q;

  logic tag_out;
  logic tag_pending;

  // The tag enters on the cycle the read is presented, so it lines up with prod_in.
  mac_valid_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .in_i       (mem_en_q),
    .out_o      (tag_out),
    .any_busy_o (tag_pending)
  );

  // NOTE: default assignment first, so every path drives acc_d and no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    if (tag_out) begin
      acc_d = acc_q + ACC_W'(bus.prod_in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      mem_en_q    <= 1'b0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_q <= acc_d;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            acc_q  <= '0;
            busy_q <= 1'b1;
            if (bus.count != '0) begin
              state_q  <= ST_ISSUE;
              mem_en_q <= 1'b1;
              addr_q   <= bus.base_addr;
              remain_q <= bus.count;
            end else begin
              state_q     <= ST_DONE;
              res_valid_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          remain_q <= remain_q - CNT_ONE;
          if (remain_q == CNT_ONE) begin
            mem_en_q <= 1'b0;
            state_q  <= ST_DRAIN;
          end else begin
            addr_q <= addr_q + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          // Leave on the edge that accumulates the last product, so result is final in DONE.
          if (!tag_pending) begin
            state_q     <= ST_DONE;
            res_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.result    = acc_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mac_issue_sequencer.sv
// Bench for mac_issue_sequencer: behavioural BRAM + multiplier, directed vector table,
// reset-abort sequence and randomized jobs checked against a sum-of-products model.
module tb_mac_issue_sequencer;
  import mac_ctrl_pkg::*;

  localparam int LAT = RD_LAT + MUL_LAT;

  typedef enum int {F_T1, F_T2, F_ALL15} fill_e;

  typedef struct {
    logic [3:0]  base;
    logic [4:0]  count;
    fill_e       fill;
    int          hold;
    int          exp_lat;
    int unsigned exp_res;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_issue_sequencer_if bus ();

  mac_issue_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] a_mem [16];
  logic [3:0] y_mem [16];
  bit         sched_v [64];
  logic [7:0] sched_p [64];
  logic [3:0] addr_log [$];
  vec_t       vecs [6];

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM + multiplier model: a read seen now yields a*y on prod_in LAT cycles later;
  // cycles with no product get random junk that the sequencer must ignore.
  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) begin
      addr_log.push_back(bus.mem_addr);
      sched_p[(cyc + LAT) % 64] = 8'(a_mem[bus.mem_addr]) * 8'(y_mem[bus.mem_addr]);
      sched_v[(cyc + LAT) % 64] = 1'b1;
    end
    if (sched_v[cyc % 64]) begin
      bus.prod_in = sched_p[cyc % 64];
      sched_v[cyc % 64] = 1'b0;
    end else begin
      bus.prod_in = 8'($urandom);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_mem(input fill_e f);
    for (int i = 0; i < 16; i++) begin
      case (f)
        F_T1:    begin a_mem[i] = (i == 0) ? 4'd3 : 4'd0; y_mem[i] = (i == 0) ? 4'd5 : 4'd0; end
        F_T2:    begin a_mem[i] = 4'((i + 15) % 16);     y_mem[i] = 4'((i + 3) % 16); end
        default: begin a_mem[i] = 4'd15;                 y_mem[i] = 4'd15; end
      endcase
    end
  endtask

  function automatic int unsigned model_sum(input int base, input int count);
    int unsigned s = 0;
    for (int k = 0; k < count; k++) begin
      int idx = (base + k) % 16;
      s += int'(a_mem[idx]) * int'(y_mem[idx]);
    end
    return s % 65536;
  endfunction

  // Caller is at a falling edge with the sequencer idle.
  task automatic run_job(input logic [3:0] base, input logic [4:0] count, input int hold,
                         input int unsigned exp_res, input int exp_lat, input string tag);
    int t_start;
    int lat;
    int bad;
    addr_log.delete();
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.count     = count;
    t_start       = cyc + 1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.base_addr = 4'($urandom);
    bus.count     = 5'($urandom_range(0, 16));
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      if (bus.res_valid === 1'b1) begin
        lat = cyc - t_start;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, 32'(bus.result), exp_res);
    check({tag, "_reads"}, addr_log.size(), 32'(count));
    bad = 0;
    for (int k = 0; k < addr_log.size(); k++) begin
      if (addr_log[k] !== 4'((int'(base) + k) % 16)) bad++;
    end
    check({tag, "_addr_bad"}, bad, 0);
    for (int h = 0; h < hold; h++) begin
      bus.start     = (h % 2 == 0);
      bus.base_addr = 4'($urandom);
      bus.count     = 5'($urandom_range(1, 16));
      bus.res_ready = 1'b0;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_hold_result"}, 32'(bus.result), exp_res);
    end
    bus.res_ready = 1'b1;
    bus.start     = (hold > 0);
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    check({tag, "_acc_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_acc_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_acc_mem_en"}, 32'(bus.mem_en), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rb;
    logic [4:0]  rc;
    int          rh;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.count     = '0;
    bus.res_ready = 1'b0;
    fill_mem(F_ALL15);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    vecs[0] = '{4'd0,  5'd1,  F_T1,    0,  14, 15};
    vecs[1] = '{4'd2,  5'd4,  F_T2,    0,  17, 70};
    vecs[2] = '{4'd14, 5'd4,  F_T2,    0,  17, 86};
    vecs[3] = '{4'd5,  5'd16, F_ALL15, 2,  29, 3600};
    vecs[4] = '{4'd9,  5'd0,  F_T2,    0,  0,  0};
    vecs[5] = '{4'd7,  5'd3,  F_T2,    10, 16, 233};

    for (int v = 0; v < 6; v++) begin
      fill_mem(vecs[v].fill);
      run_job(vecs[v].base, vecs[v].count, vecs[v].hold, vecs[v].exp_res, vecs[v].exp_lat,
              $sformatf("vec%0d", v));
    end

    // Abort a job mid-issue, then make sure a fresh job is unaffected by stale products.
    fill_mem(F_T2);
    bus.start     = 1'b1;
    bus.base_addr = 4'd3;
    bus.count     = 5'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_pre_mem_en", 32'(bus.mem_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    run_job(4'd10, 5'd5, 0, model_sum(10, 5), 5 + LAT, "post_abort");

    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < 16; i++) begin
        a_mem[i] = 4'($urandom);
        y_mem[i] = 4'($urandom);
      end
      rb = 4'($urandom);
      rc = 5'($urandom_range(0, 16));
      rh = $urandom_range(0, 3);
      run_job(rb, rc, rh, model_sum(int'(rb), int'(rc)), (rc == 0) ? 0 : int'(rc) + LAT,
              $sformatf("rand%0d", j));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
